display_timings_480p: RTL and testbench

DISPLAY_TIMINGS_480P -- requirements
Module: display_timings_480p

---
 rtl/display_timing_pkg.sv | 21 ++
 rtl/timing_axis.sv | 67 ++++++
 rtl/display_timings_480p.sv | 93 +++++++++
 tb/tb_display_timings_480p.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_timing_pkg.sv
// Shared phase encoding and 640x480@60 default timing constants for the
// display timing generator.
package display_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

endpackage

// File: rtl/timing_axis.sv
// One axis of the raster: a wrapping position counter plus the
// ACTIVE->FRONT->SYNC->BACK phase machine, exposing the next phase so the
// parent can register outputs coincident with the counter.
module timing_axis
  import display_timing_pkg::*;
#(
  parameter int CORDW      = 10,
  parameter int LEN_ACTIVE = DEF_H_ACTIVE,
  parameter int LEN_FRONT  = DEF_H_FRONT,
  parameter int LEN_SYNC   = DEF_H_SYNC,
  parameter int LEN_BACK   = DEF_H_BACK
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CORDW-1:0] count_o,
  output phase_e           phase_next_o,
  output logic             wrap_o
);

  localparam int TOTAL = LEN_ACTIVE + LEN_FRONT + LEN_SYNC + LEN_BACK;

  if (TOTAL > (1 << CORDW)) begin : g_total_check
    $error("timing_axis: total count does not fit in CORDW bits");
  end

  localparam logic [CORDW-1:0] LAST_ACTIVE = CORDW'(LEN_ACTIVE - 1);
  localparam logic [CORDW-1:0] LAST_FRONT  = CORDW'(LEN_ACTIVE + LEN_FRONT - 1);
  localparam logic [CORDW-1:0] LAST_SYNC   = CORDW'(LEN_ACTIVE + LEN_FRONT + LEN_SYNC - 1);
  localparam logic [CORDW-1:0] LAST_TOTAL  = CORDW'(TOTAL - 1);

  logic [CORDW-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;

  assign wrap_o       = en_i && (count_q == LAST_TOTAL);
  assign count_o      = count_q;
  assign phase_next_o = phase_d;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    count_d = count_q;
    phase_d = phase_q;
    if (en_i) begin
      count_d = (count_q == LAST_TOTAL) ? '0 : count_q + CORDW'(1);
      case (phase_q)
        ACTIVE:  if (count_q == LAST_ACTIVE) phase_d = FRONT;
        FRONT:   if (count_q == LAST_FRONT)  phase_d = SYNC;
        SYNC:    if (count_q == LAST_SYNC)   phase_d = BACK;
        BACK:    if (count_q == LAST_TOTAL)  phase_d = ACTIVE;
        default: phase_d = BACK;
      endcase
    end
  end

  // Reset parks on the last position so the first advance lands on 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= LAST_TOTAL;
      phase_q <= BACK;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/display_timings_480p.sv
// Raster timing generator: horizontal and vertical axis counters with
// registered sync, data-enable and start-of-line/frame strobes.
module display_timings_480p
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int SYNC_POL = 0,
  parameter int CORDW    = 10
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             clk_locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line
);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic   h_wrap, v_wrap;
  phase_e h_phase_next, v_phase_next;

  timing_axis #(
    .CORDW(CORDW), .LEN_ACTIVE(H_ACTIVE), .LEN_FRONT(H_FRONT),
    .LEN_SYNC(H_SYNC), .LEN_BACK(H_BACK)
  ) u_h_axis (
    .clk_i        (clk_pix),
    .rst_ni       (rst_n),
    .en_i         (clk_locked),
    .count_o      (sx),
    .phase_next_o (h_phase_next),
    .wrap_o       (h_wrap)
  );

  // The vertical axis only moves on the horizontal wrap, which already
  // implies clk_locked; its own wrap therefore marks landing on (0,0).
  timing_axis #(
    .CORDW(CORDW), .LEN_ACTIVE(V_ACTIVE), .LEN_FRONT(V_FRONT),
    .LEN_SYNC(V_SYNC), .LEN_BACK(V_BACK)
  ) u_v_axis (
    .clk_i        (clk_pix),
    .rst_ni       (rst_n),
    .en_i         (h_wrap),
    .count_o      (sy),
    .phase_next_o (v_phase_next),
    .wrap_o       (v_wrap)
  );

  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic frame_q, frame_d, line_q, line_d;

  always_comb begin
    de_d    = (h_phase_next == ACTIVE) && (v_phase_next == ACTIVE);
    hsync_d = (h_phase_next == SYNC) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d = (v_phase_next == SYNC) ? SYNC_ACT : ~SYNC_ACT;
    line_d  = h_wrap;
    frame_d = v_wrap;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign frame = frame_q;
  assign line  = line_q;

endmodule

// File: tb/tb_display_timings_480p.sv
// Scoreboard bench: the driver pushes model-predicted outputs per clock, a
// negedge monitor pops and compares both polarity variants of the generator.
module tb_display_timings_480p;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 24;
  localparam int V_FRONT  = 3;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 4;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 33;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
    logic       hs_act;
    logic       vs_act;
    logic       frame;
    logic       line;
  } exp_t;

  logic       clk_pix = 1'b0;
  logic       rst_n;
  logic       clk_locked;
  logic [9:0] sx0, sy0, sx1, sy1;
  logic       hs0, vs0, de0, fr0, ln0;
  logic       hs1, vs1, de1, fr1, ln1;

  always #5 clk_pix = ~clk_pix;

  display_timings_480p #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_POL(0), .CORDW(10)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .clk_locked(clk_locked),
    .sx(sx0), .sy(sy0), .hsync(hs0), .vsync(vs0), .de(de0),
    .frame(fr0), .line(ln0)
  );

  display_timings_480p #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_POL(1), .CORDW(10)
  ) dut_p1 (
    .clk_pix(clk_pix), .rst_n(rst_n), .clk_locked(clk_locked),
    .sx(sx1), .sy(sy1), .hsync(hs1), .vsync(vs1), .de(de1),
    .frame(fr1), .line(ln1)
  );

  int   checks = 0;
  int   failures = 0;
  bit   summary_done = 1'b0;
  exp_t sb_q[$];

  task automatic print_summary();
    if (!summary_done) begin
      summary_done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      if (failures >= 50) begin
        print_summary();
        $finish;
      end
    end
  endtask

  // Reference position model: plain counters, no phase machine.
  int   mx, my;
  logic mf, ml;

  task automatic model_reset();
    mx = H_TOTAL - 1;
    my = V_TOTAL - 1;
    mf = 1'b0;
    ml = 1'b0;
  endtask

  task automatic model_step(input logic lk);
    mf = 1'b0;
    ml = 1'b0;
    if (lk) begin
      if (mx == H_TOTAL - 1) begin
        mx = 0;
        ml = 1'b1;
        if (my == V_TOTAL - 1) begin
          my = 0;
          mf = 1'b1;
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.sx     = 10'(mx);
    e.sy     = 10'(my);
    e.de     = (mx < 640) && (my < 24);
    e.hs_act = (mx >= 656) && (mx < 752);
    e.vs_act = (my >= 27) && (my < 29);
    e.frame  = mf;
    e.line   = ml;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic lk);
    clk_locked = lk;
    @(posedge clk_pix);
    if (rst_n) model_step(lk);
    push_exp();
    #1;
  endtask

  task automatic run_to(input int x, input int y);
    for (int n = 0; n < 30000; n++) begin
      if (mx == x && my == y) break;
      cycle(1'b1);
    end
  endtask

  // Scoreboard monitor: one expected entry per clock for both instances.
  exp_t        e_m;
  logic [24:0] a0, a1;

  always @(negedge clk_pix) begin
    if (sb_q.size() == 0) begin
      check("sb_underflow", sb_q.size(), 1);
    end else begin
      e_m = sb_q.pop_front();
      a0  = {sx0, sy0, de0, ~hs0, ~vs0, fr0, ln0};
      a1  = {sx1, sy1, de1, hs1, vs1, fr1, ln1};
      check("cycle_pol0", {7'd0, a0}, {7'd0, e_m});
      check("cycle_pol1", {7'd0, a1}, {7'd0, e_m});
    end
  end

  // Hand-computed boundary probes: {de, hsync active, vsync active, line}.
  localparam int NP = 12;
  int         probe_x [NP] = '{639, 640, 655, 656, 751, 752, 799, 0, 639, 0, 100, 100};
  int         probe_y [NP] = '{0,   0,   0,   0,   751 - 751, 0, 0, 1, 23, 24, 27, 29};
  logic [3:0] probe_v [NP] = '{4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                               4'b0000, 4'b1001, 4'b1000, 4'b0001, 4'b0010, 4'b0000};
  int         probe_hits [NP];

  // Per-frame statistics on the default-polarity instance.
  int   win_cyc, win_de, win_ln, win_hsp, win_hs_bad, win_vsc, win_vsp, hs_run;
  bit   win_open = 1'b0;
  logic hs_prev, vs_prev;

  always @(negedge clk_pix) begin
    if (!rst_n) begin
      win_open = 1'b0;
      hs_run   = 0;
      hs_prev  = 1'b0;
      vs_prev  = 1'b0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (sx0 == 10'(probe_x[i]) && sy0 == 10'(probe_y[i])) begin
          probe_hits[i]++;
          check($sformatf("probe_%0d_%0d", probe_x[i], probe_y[i]),
                {28'd0, de0, ~hs0, ~vs0, ln0}, {28'd0, probe_v[i]});
        end
      end
      if (fr0) begin
        if (win_open) begin
          check("frame_interval", win_cyc, 26400);
          check("frame_de_cycles", win_de, 15360);
          check("frame_line_pulses", win_ln, 33);
          check("frame_hsync_pulses", win_hsp, 33);
          check("frame_hsync_bad_width", win_hs_bad, 0);
          check("frame_vsync_cycles", win_vsc, 1600);
          check("frame_vsync_pulses", win_vsp, 1);
        end
        win_cyc = 0; win_de = 0; win_ln = 0; win_hsp = 0;
        win_hs_bad = 0; win_vsc = 0; win_vsp = 0;
        win_open = 1'b1;
      end
      win_cyc++;
      if (de0) win_de++;
      if (ln0) win_ln++;
      if (!hs0) begin
        hs_run++;
      end else if (hs_prev) begin
        win_hsp++;
        if (hs_run != 96) win_hs_bad++;
        hs_run = 0;
      end
      hs_prev = ~hs0;
      if (!vs0) begin
        win_vsc++;
        if (!vs_prev) win_vsp++;
      end
      vs_prev = ~vs0;
      if (!clk_locked) win_open = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NP; i++) probe_hits[i] = 0;
    rst_n      = 1'b0;
    clk_locked = 1'b1;
    model_reset();
    repeat (3) cycle(1'b1);

    // Release and run one full frame back onto (0,0).
    rst_n = 1'b1;
    cycle(1'b1);
    repeat (H_TOTAL * V_TOTAL) cycle(1'b1);

    // Lock lost right after landing on (0,0): strobes must drop.
    repeat (5) cycle(1'b0);

    // Lock lost mid-line for 37 cycles, then resume one pixel further.
    run_to(300, 20);
    repeat (37) cycle(1'b0);
    cycle(1'b1);

    // Asynchronous reset landing inside the vsync pulse.
    run_to(99, 27);
    clk_locked = 1'b1;
    @(posedge clk_pix);
    model_step(1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    #1;
    repeat (2) cycle(1'b1);
    rst_n = 1'b1;
    repeat (3) cycle(1'b1);

    @(negedge clk_pix);
    #1;
    for (int i = 0; i < NP; i++)
      check($sformatf("probe_hit_%0d", i), {31'd0, probe_hits[i] != 0}, 1);
    check("sb_drained", sb_q.size(), 0);
    print_summary();
    $finish;
  end

endmodule
